// File: rtl/rf_pkg.sv
// Shared defaults and types for the integer register file with busy scoreboard.
package rf_pkg;
  localparam int REG_WIDTH_DEF = 32;
  localparam int NAME_BITS_DEF = 5;
  localparam int NUM_RD_DEF    = 2;
  localparam int ZERO_REG      = 0;

  typedef logic [NAME_BITS_DEF-1:0] reg_name_t;
endpackage

// File: rtl/rf_read_port.sv
// One registered read port: array word with write-through bypass and issue-aware busy.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int REG_WIDTH = REG_WIDTH_DEF,
  parameter int NAME_BITS = NAME_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_i,
  input  logic [NAME_BITS-1:0] addr_i,
  input  logic [REG_WIDTH-1:0] arr_word_i,
  input  logic                 arr_busy_i,
  input  logic                 wr_en_i,    // already qualified with ws != 0
  input  logic [NAME_BITS-1:0] ws_i,
  input  logic [REG_WIDTH-1:0] wd_i,
  input  logic                 iss_en_i,   // already qualified with iss_rd != 0
  input  logic [NAME_BITS-1:0] iss_rd_i,
  output logic [REG_WIDTH-1:0] data_o,
  output logic                 valid_o,
  output logic                 busy_o
);
  logic [REG_WIDTH-1:0] data_q, data_d;
  logic                 valid_q, busy_q, busy_d;
  logic                 wr_hit, iss_hit;

  assign wr_hit  = wr_en_i  && (ws_i     == addr_i);
  assign iss_hit = iss_en_i && (iss_rd_i == addr_i);

  // A same-cycle issue means a new producer is in flight, so it outranks the write clear.
  always_comb begin
    data_d = wr_hit ? wd_i : arr_word_i;
    busy_d = arr_busy_i;
    if (wr_hit)  busy_d = 1'b0;
    if (iss_hit) busy_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= req_i;
      if (req_i) begin
        data_q <= data_d;
        busy_q <= busy_d;
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;
endmodule

// File: rtl/rf_scoreboard.sv
// Integer register file with NUM_RD registered read ports, one write port and a busy scoreboard.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int REG_WIDTH = REG_WIDTH_DEF,
  parameter int NAME_BITS = NAME_BITS_DEF,
  parameter int NUM_RD    = NUM_RD_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_RD-1:0]             rd_req,
  input  logic [NUM_RD*NAME_BITS-1:0]   rs_addr,
  output logic [NUM_RD*REG_WIDTH-1:0]   rd_data,
  output logic [NUM_RD-1:0]             rd_valid,
  output logic [NUM_RD-1:0]             rd_busy,
  input  logic                          iss_en,
  input  logic [NAME_BITS-1:0]          iss_rd,
  input  logic                          we,
  input  logic [NAME_BITS-1:0]          ws,
  input  logic [REG_WIDTH-1:0]          wd,
  output logic [(2**NAME_BITS)-1:0]     busy_vec
);
  localparam int DEPTH = 2**NAME_BITS;

  logic [DEPTH-1:0][REG_WIDTH-1:0] regs_q;
  logic [DEPTH-1:0]                busy_q, busy_d;
  logic                            wr_ok, iss_ok;

  assign wr_ok  = we     && (ws     != NAME_BITS'(ZERO_REG));
  assign iss_ok = iss_en && (iss_rd != NAME_BITS'(ZERO_REG));

  // Set after clear: a simultaneous issue leaves the register busy for its new producer.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok)  busy_d[ws]     = 1'b0;
    if (iss_ok) busy_d[iss_rd] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
      if (wr_ok) regs_q[ws] <= wd;
    end
  end

  assign busy_vec = busy_q;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rp
    logic [NAME_BITS-1:0] addr;
    assign addr = rs_addr[g*NAME_BITS +: NAME_BITS];

    rf_read_port #(
      .REG_WIDTH (REG_WIDTH),
      .NAME_BITS (NAME_BITS)
    ) u_rp (
      .clk        (clk),
      .rst        (rst),
      .req_i      (rd_req[g]),
      .addr_i     (addr),
      .arr_word_i (regs_q[addr]),
      .arr_busy_i (busy_q[addr]),
      .wr_en_i    (wr_ok),
      .ws_i       (ws),
      .wd_i       (wd),
      .iss_en_i   (iss_ok),
      .iss_rd_i   (iss_rd),
      .data_o     (rd_data[g*REG_WIDTH +: REG_WIDTH]),
      .valid_o    (rd_valid[g]),
      .busy_o     (rd_busy[g])
    );
  end
endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard: reset, read/write, r0, bypass, scoreboard, mid-op reset.
module tb_rf_scoreboard;
  localparam int RW = 32;
  localparam int NB = 5;
  localparam int NR = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NR-1:0]      rd_req;
  logic [NR*NB-1:0]   rs_addr;
  logic [NR*RW-1:0]   rd_data;
  logic [NR-1:0]      rd_valid;
  logic [NR-1:0]      rd_busy;
  logic               iss_en;
  logic [NB-1:0]      iss_rd;
  logic               we;
  logic [NB-1:0]      ws;
  logic [RW-1:0]      wd;
  logic [(2**NB)-1:0] busy_vec;

  int n_cmp = 0;
  int n_err = 0;

  rf_scoreboard #(.REG_WIDTH(RW), .NAME_BITS(NB), .NUM_RD(NR)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rs_addr(rs_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_busy(rd_busy), .iss_en(iss_en), .iss_rd(iss_rd),
    .we(we), .ws(ws), .wd(wd), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_req = '0; rs_addr = '0; iss_en = 1'b0; iss_rd = '0;
    we = 1'b0; ws = '0; wd = '0;
  endtask

  task automatic rd2(input logic [NB-1:0] a0, input logic [NB-1:0] a1);
    rd_req = 2'b11; rs_addr = {a1, a0};
  endtask

  task automatic test_reset();
    idle();
    we = 1'b1; ws = 5'd3; wd = 32'hAA; iss_en = 1'b1; iss_rd = 5'd7;
    cyc();
    idle(); rd2(5'd3, 5'd7);
    cyc();
    idle();
    #4 rst = 1'b1;
    #1;
    n_cmp++; if (rd_data !== '0) begin n_err++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    n_cmp++; if (rd_valid !== '0) begin n_err++; $display("FAIL reset_rd_valid: got %b want 00", rd_valid); end
    n_cmp++; if (rd_busy !== '0) begin n_err++; $display("FAIL reset_rd_busy: got %b want 00", rd_busy); end
    n_cmp++; if (busy_vec !== '0) begin n_err++; $display("FAIL reset_busy_vec: got %h want 0", busy_vec); end
    #2 rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd2(NB'(2*i), NB'(2*i+1));
      cyc();
      n_cmp++; if (rd_data !== '0 || rd_valid !== 2'b11) begin
        n_err++; $display("FAIL reset_readback r%0d/r%0d: got data %h valid %b want 0 11", 2*i, 2*i+1, rd_data, rd_valid);
      end
    end
    idle();
  endtask

  task automatic test_write_read();
    idle(); we = 1'b1; ws = 5'd1; wd = 32'h1;
    cyc();
    idle(); rd2(5'd1, 5'd0);
    cyc();
    n_cmp++; if (rd_data !== {32'h0, 32'h1}) begin n_err++; $display("FAIL wr_rd_data: got %h want 0000000000000001", rd_data); end
    n_cmp++; if (rd_valid !== 2'b11) begin n_err++; $display("FAIL wr_rd_valid: got %b want 11", rd_valid); end
    n_cmp++; if (rd_busy !== 2'b00) begin n_err++; $display("FAIL wr_rd_busy: got %b want 00", rd_busy); end
    idle(); rs_addr = {5'd9, 5'd9};
    cyc();
    n_cmp++; if (rd_valid !== 2'b00) begin n_err++; $display("FAIL hold_valid: got %b want 00", rd_valid); end
    n_cmp++; if (rd_data !== {32'h0, 32'h1}) begin n_err++; $display("FAIL hold_data: got %h want 0000000000000001", rd_data); end
  endtask

  task automatic test_zero_reg();
    idle(); we = 1'b1; ws = 5'd0; wd = 32'hFFFF_FFFF; iss_en = 1'b1; iss_rd = 5'd0;
    cyc();
    n_cmp++; if (busy_vec[0] !== 1'b0) begin n_err++; $display("FAIL zero_busy_vec0: got %b want 0", busy_vec[0]); end
    idle(); rd2(5'd0, 5'd0);
    cyc();
    n_cmp++; if (rd_data !== '0) begin n_err++; $display("FAIL zero_rd_data: got %h want 0", rd_data); end
    n_cmp++; if (rd_busy !== 2'b00) begin n_err++; $display("FAIL zero_rd_busy: got %b want 00", rd_busy); end
    idle();
  endtask

  task automatic test_bypass();
    idle(); we = 1'b1; ws = 5'd31; wd = 32'h3; rd2(5'd31, 5'd1);
    cyc();
    n_cmp++; if (rd_data !== {32'h1, 32'h3}) begin n_err++; $display("FAIL byp_data: got %h want 0000000100000003", rd_data); end
    n_cmp++; if (rd_busy !== 2'b00) begin n_err++; $display("FAIL byp_busy: got %b want 00", rd_busy); end
    // write+issue+read of the same register: new data, still busy
    idle(); we = 1'b1; ws = 5'd30; wd = 32'h9; iss_en = 1'b1; iss_rd = 5'd30; rd2(5'd30, 5'd30);
    cyc();
    n_cmp++; if (rd_data !== {32'h9, 32'h9}) begin n_err++; $display("FAIL byp_iss_data: got %h want 0000000900000009", rd_data); end
    n_cmp++; if (rd_busy !== 2'b11) begin n_err++; $display("FAIL byp_iss_busy: got %b want 11", rd_busy); end
    n_cmp++; if (busy_vec[30] !== 1'b1) begin n_err++; $display("FAIL byp_iss_vec30: got %b want 1", busy_vec[30]); end
    // issue-read race without write
    idle(); iss_en = 1'b1; iss_rd = 5'd12; rd2(5'd12, 5'd31);
    cyc();
    n_cmp++; if (rd_busy !== 2'b01) begin n_err++; $display("FAIL race_busy: got %b want 01", rd_busy); end
    n_cmp++; if (rd_data !== {32'h3, 32'h0}) begin n_err++; $display("FAIL race_data: got %h want 0000000300000000", rd_data); end
    idle();
  endtask

  task automatic test_scoreboard();
    idle(); iss_en = 1'b1; iss_rd = 5'd5;
    cyc();
    n_cmp++; if (busy_vec[5] !== 1'b1) begin n_err++; $display("FAIL sb_set: got %b want 1", busy_vec[5]); end
    idle(); rd2(5'd5, 5'd4);
    cyc();
    n_cmp++; if (rd_busy !== 2'b01) begin n_err++; $display("FAIL sb_rd_busy: got %b want 01", rd_busy); end
    idle(); we = 1'b1; ws = 5'd5; wd = 32'h7; iss_en = 1'b1; iss_rd = 5'd5;
    cyc();
    n_cmp++; if (busy_vec[5] !== 1'b1) begin n_err++; $display("FAIL sb_set_wins: got %b want 1", busy_vec[5]); end
    idle(); rd2(5'd5, 5'd5);
    cyc();
    n_cmp++; if (rd_data !== {32'h7, 32'h7} || rd_busy !== 2'b11) begin
      n_err++; $display("FAIL sb_rd_after: got %h/%b want 0000000700000007/11", rd_data, rd_busy);
    end
    idle(); we = 1'b1; ws = 5'd5; wd = 32'h8;
    cyc();
    n_cmp++; if (busy_vec[5] !== 1'b0) begin n_err++; $display("FAIL sb_clear: got %b want 0", busy_vec[5]); end
    n_cmp++; if (busy_vec !== 32'h4000_1000) begin n_err++; $display("FAIL sb_vec: got %h want 40001000", busy_vec); end
    idle();
  endtask

  task automatic test_back_to_back();
    idle(); we = 1'b1; ws = 5'd10; wd = 32'hA;
    cyc();
    idle(); we = 1'b1; ws = 5'd11; wd = 32'hB; rd2(5'd10, 5'd11);
    cyc();
    idle(); rd2(5'd11, 5'd5);
    n_cmp++; if (rd_data !== {32'hB, 32'hA}) begin n_err++; $display("FAIL b2b_1: got %h want 0000000b0000000a", rd_data); end
    cyc();
    n_cmp++; if (rd_data !== {32'h8, 32'hB}) begin n_err++; $display("FAIL b2b_2: got %h want 000000080000000b", rd_data); end
    idle();
  endtask

  task automatic test_reset_midop();
    idle(); iss_en = 1'b1; iss_rd = 5'd5;
    cyc();
    iss_rd = 5'd9;
    cyc();
    idle();
    n_cmp++; if (busy_vec[5] !== 1'b1 || busy_vec[9] !== 1'b1) begin
      n_err++; $display("FAIL mid_pre: got %h want bits 5,9 set", busy_vec);
    end
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (busy_vec !== '0) begin n_err++; $display("FAIL mid_busy_vec: got %h want 0", busy_vec); end
    #2 rst = 1'b0;
    rd2(5'd5, 5'd9);
    cyc();
    n_cmp++; if (rd_data !== '0 || rd_busy !== 2'b00 || rd_valid !== 2'b11) begin
      n_err++; $display("FAIL mid_readback: got %h/%b/%b want 0/00/11", rd_data, rd_busy, rd_valid);
    end
    n_cmp++; if (busy_vec !== '0) begin n_err++; $display("FAIL mid_post_vec: got %h want 0", busy_vec); end
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #12 rst = 1'b0;
    cyc();
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_scoreboard();
    test_back_to_back();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
